// File: rtl/csam_accumulator.sv
// Group accumulator behind the CSAM multiplier: sums unsigned products over a
// valid/ready stream and holds each group's sum, term count and overflow flag.
module csam_accumulator #(
   parameter int XW    = 8,
   parameter int YW    = 5,
   parameter int PW    = XW + YW,
   parameter int ACC_W = 20,
   parameter int TERMS = 16,
   parameter int SAT   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         p_valid,
   output logic                         p_ready,
   input  logic [PW-1:0]                p_data,
   input  logic                         p_last,
   output logic                         acc_valid,
   input  logic                         acc_ready,
   output logic [ACC_W-1:0]             acc_data,
   output logic [$clog2(TERMS+1)-1:0]   acc_count,
   output logic                         acc_ovf
);

   localparam int CW = $clog2(TERMS + 1);

   typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ACC_W-1:0]  r_acc;
   logic [CW-1:0]     r_count;
   logic              r_ovf;

   logic              w_take;
   logic              w_done;
   logic [ACC_W:0]    w_sum;
   logic [CW-1:0]     w_count_inc;

   // Carry out of the accumulator either pins the sum at full scale or wraps.
   function automatic logic [ACC_W-1:0] f_sat(input logic [ACC_W:0] sum);
      if (sum[ACC_W] && (SAT != 0))
         return '1;
      return sum[ACC_W-1:0];
   endfunction

   assign w_take      = p_valid && p_ready;
   assign w_done      = acc_valid && acc_ready;
   assign w_sum       = {1'b0, r_acc} + (ACC_W+1)'(p_data);
   assign w_count_inc = r_count + CW'(1);

   always_comb begin
      w_state_nxt = r_state;
      p_ready     = 1'b0;
      acc_valid   = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            p_ready = !reset;
            if (p_valid && (p_last || (w_count_inc == CW'(TERMS))))
               w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            acc_valid = 1'b1;
            if (acc_ready)
               w_state_nxt = ST_ACCUM;
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_ACCUM;
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_acc   <= f_sat(w_sum);
            r_count <= w_count_inc;
            if (w_sum[ACC_W])
               r_ovf <= 1'b1;
         end else if (w_done) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
         end
      end
   end

   assign acc_data  = r_acc;
   assign acc_count = r_count;
   assign acc_ovf   = r_ovf;

endmodule

// File: tb/tb_csam_accumulator.sv
// Self-checking bench: three accumulator configurations driven by one stream,
// each compared every cycle against a transaction-level model.
module tb_csam_accumulator;

   localparam int PW = 13;
   localparam int CW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          p_valid;
   logic          p_last;
   logic          acc_ready;
   logic [PW-1:0] p_data;

   logic          rdy [3];
   logic          vld [3];
   logic          ovf [3];
   logic [CW-1:0] cnt [3];
   logic [19:0]   dat0;
   logic [15:0]   dat1;
   logic [15:0]   dat2;

   csam_accumulator #(.ACC_W(20), .SAT(1)) u_dut0 (
      .clk(clk), .reset(reset), .p_valid(p_valid), .p_ready(rdy[0]),
      .p_data(p_data), .p_last(p_last), .acc_valid(vld[0]), .acc_ready(acc_ready),
      .acc_data(dat0), .acc_count(cnt[0]), .acc_ovf(ovf[0]));

   csam_accumulator #(.ACC_W(16), .SAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .p_valid(p_valid), .p_ready(rdy[1]),
      .p_data(p_data), .p_last(p_last), .acc_valid(vld[1]), .acc_ready(acc_ready),
      .acc_data(dat1), .acc_count(cnt[1]), .acc_ovf(ovf[1]));

   csam_accumulator #(.ACC_W(16), .SAT(0)) u_dut2 (
      .clk(clk), .reset(reset), .p_valid(p_valid), .p_ready(rdy[2]),
      .p_data(p_data), .p_last(p_last), .acc_valid(vld[2]), .acc_ready(acc_ready),
      .acc_data(dat2), .acc_count(cnt[2]), .acc_ovf(ovf[2]));

   // Model: per configuration, the running group sum, its term count, the
   // overflow flag and whether a finished group is waiting for the consumer.
   int     m_w   [3] = '{20, 16, 16};
   bit     m_sat [3] = '{1'b1, 1'b1, 1'b0};
   longint m_sum [3] = '{0, 0, 0};
   int     m_cnt [3] = '{0, 0, 0};
   bit     m_ovf [3] = '{1'b0, 1'b0, 1'b0};
   bit     m_hold[3] = '{1'b0, 1'b0, 1'b0};
   bit     m_acc;

   int n_chk = 0;
   int n_err = 0;

   function automatic longint dat(int k);
      case (k)
         0:       return longint'(dat0);
         1:       return longint'(dat1);
         default: return longint'(dat2);
      endcase
   endfunction

   task automatic cmp(int k, string nm, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
      end
   endtask

   task automatic model_step();
      longint full;
      longint s;
      m_acc = p_valid && !m_hold[0] && !reset;
      for (int k = 0; k < 3; k++) begin
         full = (longint'(1) << m_w[k]) - 1;
         if (reset) begin
            m_hold[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
         end else if (m_hold[k]) begin
            if (acc_ready) begin
               m_hold[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end
         end else if (p_valid) begin
            s = m_sum[k] + longint'(p_data);
            if (s > full) begin
               m_ovf[k] = 1;
               s = m_sat[k] ? full : (s % (full + 1));
            end
            m_sum[k] = s;
            m_cnt[k]++;
            if (p_last || m_cnt[k] == 16)
               m_hold[k] = 1;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         cmp(k, "p_ready",   longint'(rdy[k]), longint'(!m_hold[k] && !reset));
         cmp(k, "acc_valid", longint'(vld[k]), longint'(m_hold[k]));
         cmp(k, "acc_data",  dat(k),           m_sum[k]);
         cmp(k, "acc_count", longint'(cnt[k]), longint'(m_cnt[k]));
         cmp(k, "acc_ovf",   longint'(ovf[k]), longint'(m_ovf[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drv(bit v, int d, bit l);
      p_valid = v;
      p_data  = PW'(d);
      p_last  = l;
   endtask

   bit stall_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      reset = 1'b1; acc_ready = 1'b0; drv(0, 0, 0);
      tick(); tick();
      cmp(0, "rst_valid", longint'(vld[0]), 0);
      cmp(0, "rst_data",  dat(0), 0);
      cmp(0, "rst_ready", longint'(rdy[0]), 0);

      // basic group of four
      reset = 1'b0; acc_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv(1, 15, i == 3);
         tick();
      end
      cmp(0, "basic_valid", longint'(vld[0]), 1);
      cmp(0, "basic_data",  dat(0), 60);
      cmp(0, "basic_count", longint'(cnt[0]), 4);
      cmp(0, "basic_ovf",   longint'(ovf[0]), 0);
      drv(0, 0, 0); tick();
      cmp(0, "basic_ready_after", longint'(rdy[0]), 1);

      // full group closes on the term limit
      acc_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drv(1, 7905, 0);
         tick();
      end
      cmp(0, "full_data",  dat(0), 126480);
      cmp(0, "full_count", longint'(cnt[0]), 16);
      cmp(0, "full_ovf",   longint'(ovf[0]), 0);
      cmp(0, "full_valid", longint'(vld[0]), 1);
      drv(0, 0, 0); acc_ready = 1'b1; tick();

      // saturate / wrap on a 16-bit accumulator
      acc_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drv(1, 7905, i == 8);
         tick();
      end
      cmp(1, "sat_data",   dat(1), 65535);
      cmp(1, "sat_ovf",    longint'(ovf[1]), 1);
      cmp(1, "sat_count",  longint'(cnt[1]), 9);
      cmp(2, "wrap_data",  dat(2), 5609);
      cmp(2, "wrap_ovf",   longint'(ovf[2]), 1);
      cmp(0, "wide_data",  dat(0), 71145);

      // backpressure on the held result
      drv(1, 100, 0);
      repeat (5) tick();
      cmp(0, "bp_ready", longint'(rdy[0]), 0);
      cmp(1, "bp_data",  dat(1), 65535);
      acc_ready = 1'b1; tick();
      cmp(0, "bp_cleared", dat(0), 0);
      tick();
      cmp(0, "bp_first",  dat(0), 100);
      cmp(0, "bp_count1", longint'(cnt[0]), 1);
      drv(1, 5, 1); tick();
      cmp(0, "bp_close", dat(0), 105);
      drv(0, 0, 0); tick();

      // producer stalls add nothing
      acc_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drv(stall_pat[i], 3, i == 4);
         tick();
      end
      cmp(0, "stall_data",  dat(0), 9);
      cmp(0, "stall_count", longint'(cnt[0]), 3);
      drv(0, 0, 0); acc_ready = 1'b1; tick();

      // last flag on the sixteenth term: one close only
      acc_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drv(1, 1, i == 15);
         tick();
      end
      cmp(0, "lastT_count", longint'(cnt[0]), 16);
      drv(0, 0, 0); acc_ready = 1'b1; tick(); tick();
      cmp(0, "lastT_noempty", longint'(vld[0]), 0);

      // reset in the middle of a group
      for (int i = 0; i < 2; i++) begin
         drv(1, 50, 0);
         tick();
      end
      drv(0, 0, 0); reset = 1'b1; tick();
      cmp(0, "mid_rst_data",  dat(0), 0);
      cmp(0, "mid_rst_count", longint'(cnt[0]), 0);
      reset = 1'b0; drv(1, 7, 1); tick();
      cmp(0, "post_rst_data",  dat(0), 7);
      cmp(0, "post_rst_count", longint'(cnt[0]), 1);
      drv(0, 0, 0); tick();

      // randomized traffic; a product not taken stays on the bus
      for (int c = 0; c < 3000; c++) begin
         acc_ready = 1'($urandom_range(0, 1));
         reset     = ($urandom_range(0, 149) == 0);
         if (!(p_valid && !m_acc))
            drv(($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0) ? 7905 : int'($urandom_range(0, 7905)),
                ($urandom_range(0, 5) == 0));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/csam_accumulator.md
Name: csam_accumulator

Overview:
- Downstream consumer of the CSAM carry-save array multiplier: accepts unsigned products one per cycle over a valid/ready handshake and sums a group of them into a wide accumulator.
- Closes a group on an explicit last flag or when a term-count limit is reached.
- Presents the sum, term count and an overflow flag on a holding output handshake, which together form a multiply-accumulate (dot-product) path behind the multiplier array.

Parameters:
- XW, 8, multiplicand width feeding CSAM.
- YW, 5, multiplier width feeding CSAM.
- PW, XW+YW (13), product width consumed.
- ACC_W, 20, accumulator width; must be >= PW.
- TERMS, 16, maximum products per group; must be >= 1.
- SAT, 1, 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- p_valid  input  1  product valid from the multiplier stage.
- p_ready  output  1  block can accept a product this cycle.
- p_data  input  PW  unsigned product.
- p_last  input  1  marks the final product of a group; only meaningful with p_valid.
- acc_valid  output  1  group result available.
- acc_ready  input  1  consumer accepts the result.
- acc_data  output  ACC_W  accumulated sum.
- acc_count  output  $clog2(TERMS+1)  number of products in the group.
- acc_ovf  output  1  sticky: at least one addition in the group overflowed ACC_W.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=ACCUM, acc_data=0, acc_count=0, acc_ovf=0, acc_valid=0. p_ready=0 in any cycle where reset=1.
- A product transfer occurs on the rising edge where p_valid && p_ready. A result transfer occurs on the rising edge where acc_valid && acc_ready.
- State ACCUM:
  - p_ready=1, acc_valid=0.
  - On a product transfer: sum = acc_data + p_data, computed at ACC_W+1 bits.
  - If sum bit ACC_W is set: acc_ovf<=1, and acc_data<=all-ones if SAT=1, else sum[ACC_W-1:0]. Otherwise acc_data<=sum.
  - acc_count<=acc_count+1.
  - If p_last=1 or the new count equals TERMS: next state HOLD.
  - Once acc_ovf is set with SAT=1, acc_data remains all-ones for the rest of the group.
- State HOLD:
  - p_ready=0; acc_valid=1.
  - acc_data, acc_count and acc_ovf are stable until the result transfer.
  - On the result transfer: acc_data<=0, acc_count<=0, acc_ovf<=0, next state ACCUM. p_ready is 1 in the following cycle.
- Latency and throughput:
  - acc_valid asserts on the cycle after the closing product is accepted.
  - Group throughput is N+1 cycles minimum for N products; no product is accepted in the HOLD cycle.
- p_valid without p_ready: the producer holds p_data and p_last stable. The block never drops or double-counts a product.
- p_last on the TERMS-th product: a single close; no empty group follows.
- Empty groups are impossible: a group always contains at least 1 product.
- acc_ready=1 in ACCUM: ignored.
- p_valid in HOLD: ignored; no state change.
- reset in either state: the group is discarded; the registers take reset values on the next edge, regardless of the handshakes.
- reset and a transfer in the same cycle: reset wins.

Test Plan:
- Basic group: 4 products of 0x00F (15) with p_last on the 4th, acc_ready=1 -> acc_valid exactly one cycle after the 4th accept; acc_data=60, acc_count=4, acc_ovf=0; p_ready=1 in the following cycle.
- Max-product full group: 16 products of 7905 (0xFF*0x1F) with no p_last -> auto-close at count 16; acc_data=126480, acc_count=16, acc_ovf=0.
- Saturation with ACC_W=16, SAT=1: 9 products of 7905 with p_last on the 9th -> acc_data=65535, acc_ovf=1, acc_count=9. Wrap variant with SAT=0 -> acc_data=5609 (71145 mod 65536), acc_ovf=1.
- Backpressure: result held with acc_ready=0 for 5 cycles while p_valid=1 with data 100 -> p_ready=0 throughout, outputs stable; after acc_ready=1, the next group starts from 0 and its first accept of 100 gives an internal sum of 100.
- Producer stalls: p_valid toggled 1,0,0,1,1 with products 3,3,3 and p_last on the last -> acc_data=9, acc_count=3; the idle cycles add nothing.
- Reset mid-group: after 2 products of 50, assert reset for 1 cycle -> acc_data=0, acc_count=0, acc_ovf=0, acc_valid=0; a subsequent single product 7 with p_last -> acc_data=7, acc_count=1.
